// File: rtl/data_mem_responder_if.sv
// Load/store port between the LSU (master) and the data memory responder (slave).
// Request fields are held by the master; gnt/rvalid/rdata/err come back from the slave.
interface data_mem_responder_if #(
  parameter int WORD_SIZE = 32
);
  logic                 req_i;
  logic                 we_i;
  logic [WORD_SIZE-1:0] addr_i;
  logic [WORD_SIZE-1:0] wdata_i;
  logic [1:0]           size_i;
  logic                 uns_i;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [WORD_SIZE-1:0] rdata_o;
  logic                 err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, size_i, uns_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, size_i, uns_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: byte/half/word load/store on a word array, one transaction at a time.
// Optional MISALIGN_CHECK_EN reports misaligned or reserved-size accesses through err_o.
module data_mem_responder #(
  parameter int WORD_SIZE   = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int IW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic gnt, take;

  logic                 we_q, uns_q;
  logic [1:0]           size_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 err_q;

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  // In IDLE the access is described by the live inputs, afterwards by the latched copy.
  logic                 f_we, f_uns, f_err;
  logic [1:0]           f_size;
  logic [WORD_SIZE-1:0] f_addr;
  logic [IW-1:0]        idx;

  assign f_we   = (state == IDLE) ? bus.we_i   : we_q;
  assign f_uns  = (state == IDLE) ? bus.uns_i  : uns_q;
  assign f_size = (state == IDLE) ? bus.size_i : size_q;
  assign f_addr = (state == IDLE) ? bus.addr_i : addr_q;
  assign idx    = f_addr[IW+1:2];

  wire unused_addr = ^f_addr[WORD_SIZE-1:IW+2];

`ifdef MISALIGN_CHECK_EN
  assign f_err = (f_size == 2'b11)
               | ((f_size == 2'b10) && (f_addr[1:0] != 2'b00))
               | ((f_size == 2'b01) && f_addr[0]);
`else
  assign f_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt     = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt = bus.req_i;
        if (bus.req_i) begin
          take = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = RESP;
        else             cnt_n   = cnt - 4'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic [WORD_SIZE-1:0] word, ld, wr_word;
  logic [4:0]           boff, hoff;
  logic [7:0]           bsel;
  logic [15:0]          hsel;

  always_comb begin
    word    = mem[idx];
    boff    = {f_addr[1:0], 3'b000};
    hoff    = {f_addr[1], 4'b0000};
    bsel    = word[boff +: 8];
    hsel    = word[hoff +: 16];
    ld      = word;
    wr_word = word;
    unique case (1'b1)
      (f_size == 2'b00): begin
        ld = {{(WORD_SIZE-8){~f_uns & bsel[7]}}, bsel};
        wr_word[boff +: 8] = wdata_q[7:0];
      end
      (f_size == 2'b01): begin
        ld = {{(WORD_SIZE-16){~f_uns & hsel[15]}}, hsel};
        wr_word[hoff +: 16] = wdata_q[15:0];
      end
      default: begin
        ld      = word;
        wr_word = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        we_q    <= bus.we_i;
        uns_q   <= bus.uns_i;
        size_q  <= bus.size_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
      end
      if (state_n == RESP) begin
        err_q   <= f_err;
        rdata_q <= (f_we | f_err) ? '0 : ld;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Stores land on the edge that closes RESP; the array itself is never reset.
  always_ff @(posedge clk) begin
    if ((state == RESP) && we_q && !f_err && !rst)
      mem[idx] <= wr_word;
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = (state == RESP);
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed spec cases plus random traffic
// checked against a byte-addressed little-endian memory model.
module tb_data_mem_responder;
  localparam int W   = 1;
  localparam int MS  = 256;
  localparam int NB  = 4 * MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  data_mem_responder_if #(.WORD_SIZE(32)) bus ();

  data_mem_responder #(
    .WORD_SIZE(32), .MEM_SIZE(MS), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] bm [NB];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size,
                       input logic uns, output logic [31:0] d,
                       output logic e);
    int nb, a, base;
    longint v;
    bit bad;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a  = int'(addr % NB);
`ifdef MISALIGN_CHECK_EN
    bad = (size == 2'd3) || (a % nb != 0);
`else
    bad = 1'b0;
`endif
    base = a - (a % nb);
    d = 32'h0;
    e = bad;
    if (!bad && we) begin
      for (int i = 0; i < nb; i++) bm[base+i] = 8'(wdata >> (8 * i));
    end else if (!bad) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(bm[base+i]) << (8 * i));
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v = v - (longint'(1) << (8 * nb));
      d = 32'(v);
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size,
                     input logic uns, output logic [31:0] rd,
                     output logic er);
    logic [31:0] ed;
    logic ee;
    int n;
    model(we, addr, wdata, size, uns, ed, ee);
    @(posedge clk); #1;
    bus.req_i = 1'b1;
    bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata;
    bus.size_i = size; bus.uns_i = uns;
    @(negedge clk);
    check("gnt", 32'(bus.gnt_o), 32'd1);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    bus.we_i = 1'($urandom); bus.addr_i = $urandom;
    bus.wdata_i = $urandom; bus.size_i = 2'($urandom);
    bus.uns_i = 1'($urandom);
    n = 0;
    @(negedge clk);
    while (!bus.rvalid_o && n < 20) begin
      check("wait_gnt", 32'(bus.gnt_o), 32'd0);
      check("wait_rdata", bus.rdata_o, 32'd0);
      bus.req_i = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.req_i = 1'b0;
    rd = bus.rdata_o;
    er = bus.err_o;
    check("latency", n, W);
    check("rdata", rd, ed);
    check("err", 32'(er), 32'(ee));
    @(posedge clk);
    @(negedge clk);
    check("pulse", 32'(bus.rvalid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
    bus.wdata_i = '0; bus.size_i = 2'b10; bus.uns_i = 1'b0;
    for (int i = 0; i < NB; i++) bm[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < MS; i++) txn(1'b1, 32'(4 * i), 32'h0, 2'b10, 1'b0, rd, er);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er);
    check("t1_lw", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h21, 32'hFFFFFF80, 2'b00, 1'b0, rd, er);
    txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er);
    check("t2_lw", rd, 32'h00008000);
    txn(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, rd, er);
    check("t2_lb", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, rd, er);
    check("t2_lbu", rd, 32'h00000080);

    txn(1'b1, 32'h32, 32'h55558001, 2'b01, 1'b0, rd, er);
    txn(1'b0, 32'h32, 32'h0, 2'b01, 1'b0, rd, er);
    check("t3_lh", rd, 32'hFFFF8001);
    txn(1'b0, 32'h32, 32'h0, 2'b01, 1'b1, rd, er);
    check("t3_lhu", rd, 32'h00008001);
    txn(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd, er);
    check("t3_lw", rd, 32'h80010000);

    txn(1'b1, 32'h400, 32'h12345678, 2'b10, 1'b0, rd, er);
    txn(1'b0, 32'h000, 32'h0, 2'b10, 1'b0, rd, er);
    check("t4_wrap", rd, 32'h12345678);

    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h40;
    bus.wdata_i = 32'hAAAAAAAA; bus.size_i = 2'b10;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    rst = 1'b1;
    #2;
    check("t5_rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rvalid", 32'(bus.rvalid_o), 32'd0);
    end
    txn(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er);
    check("t5_lw", rd, 32'h00000000);

    txn(1'b1, 32'h40, 32'h13572468, 2'b10, 1'b0, rd, er);
    txn(1'b0, 32'h42, 32'h0, 2'b10, 1'b0, rd, er);
`ifdef MISALIGN_CHECK_EN
    check("t6_rd", rd, 32'h0);
    check("t6_err", 32'(er), 32'd1);
    txn(1'b1, 32'h43, 32'hFFFFFFFF, 2'b10, 1'b0, rd, er);
    txn(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er);
    check("t6_nowrite", rd, 32'h13572468);
`else
    check("t6_rd", rd, 32'h13572468);
    check("t6_err", 32'(er), 32'd0);
`endif

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 10) | $urandom_range(0, 127);
      txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), rd, er);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
